// File: rtl/riscv_single_cycle_top.sv
// Single-cycle RV32I subset core (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal).
// ROM, register file and data memory keep fixed instance/array names so benches can preload and inspect them.

module inst_mem #(
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [29:0]              word_addr,
  output logic [31:0]              instr
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] rom [0:DEPTH-1];

  // Optional backdoor load port; the core ties it off and relies on hierarchical preloading.
  always_ff @(posedge CLK) begin
    if (load_en) begin
      rom[load_addr] <= load_data;
    end
  end

  assign instr = (word_addr < 30'(DEPTH)) ? rom[word_addr[AW-1:0]] : 32'h0000_0013;
endmodule

module reg_file (
  input  logic        CLK,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] registers [0:31];

  // Write port; x0 is never written.
  always_ff @(posedge CLK) begin
    if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0000_0000 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0000_0000 : registers[raddr2];
endmodule

module data_mem #(
  parameter int DEPTH = 16384
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [0:DEPTH-1];

  // Word write port; the index is the raw byte address, not shifted.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

module riscv_single_cycle_top #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 16384
) (
  input  logic CLK,
  input  logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } alu_op_e;
  typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3} imm_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr, imm, rs1_data, rs2_data, alu_b, alu_result, mem_rdata, wb_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        op_ok, reg_write, mem_write, alu_src_imm, branch, jump, zero, take;
  alu_op_e     alu_op;
  imm_sel_e    imm_sel;
  wb_sel_e     wb_sel;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign pc_plus4 = pc_q + 32'd4;

  // PC register; reset forces the fetch address to zero without waiting for a clock.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pc_q <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  inst_mem #(.DEPTH(IMEM_DEPTH)) instMem (
    .CLK       (CLK),
    .load_en   (1'b0),
    .load_addr ({IAW{1'b0}}),
    .load_data (32'h0000_0000),
    .word_addr (pc_q[31:2]),
    .instr     (instr)
  );

  // ALU decoder; op_ok clears for encodings outside the supported subset so they retire as nops.
  always_comb begin
    alu_op = ALU_ADD;
    op_ok  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case ({funct7, funct3})
          {7'h00, 3'b000}: begin alu_op = ALU_ADD; op_ok = 1'b1; end
          {7'h20, 3'b000}: begin alu_op = ALU_SUB; op_ok = 1'b1; end
          {7'h00, 3'b111}: begin alu_op = ALU_AND; op_ok = 1'b1; end
          {7'h00, 3'b110}: begin alu_op = ALU_OR;  op_ok = 1'b1; end
          {7'h00, 3'b010}: begin alu_op = ALU_SLT; op_ok = 1'b1; end
          default:         begin alu_op = ALU_ADD; op_ok = 1'b0; end
        endcase
      end
      OP_ITYPE: begin
        case (funct3)
          3'b000:  begin alu_op = ALU_ADD; op_ok = 1'b1; end
          3'b111:  begin alu_op = ALU_AND; op_ok = 1'b1; end
          3'b110:  begin alu_op = ALU_OR;  op_ok = 1'b1; end
          3'b010:  begin alu_op = ALU_SLT; op_ok = 1'b1; end
          default: begin alu_op = ALU_ADD; op_ok = 1'b0; end
        endcase
      end
      OP_LOAD, OP_STORE: begin alu_op = ALU_ADD; op_ok = (funct3 == 3'b010); end
      OP_BRANCH:         begin alu_op = ALU_SUB; op_ok = (funct3 == 3'b000); end
      OP_JAL:            begin alu_op = ALU_ADD; op_ok = 1'b1; end
      default:           begin alu_op = ALU_ADD; op_ok = 1'b0; end
    endcase
  end

  // Main decoder: datapath steering and write enables.
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    imm_sel     = IMM_I;
    wb_sel      = WB_ALU;
    case (opcode)
      OP_LOAD:   begin reg_write = op_ok; alu_src_imm = 1'b1; wb_sel = WB_MEM; end
      OP_STORE:  begin mem_write = op_ok; alu_src_imm = 1'b1; imm_sel = IMM_S; end
      OP_RTYPE:  begin reg_write = op_ok; end
      OP_ITYPE:  begin reg_write = op_ok; alu_src_imm = 1'b1; end
      OP_BRANCH: begin branch = op_ok; imm_sel = IMM_B; end
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; imm_sel = IMM_J; wb_sel = WB_PC4; end
      default:   begin reg_write = 1'b0; end
    endcase
  end

  // Sign-extended immediate for the selected format.
  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

  reg_file regFile (
    .CLK    (CLK),
    .we     (reg_write & ~rst),
    .waddr  (instr[11:7]),
    .wdata  (wb_data),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign alu_b = alu_src_imm ? imm : rs2_data;

  // ALU; slt is a signed compare.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = rs1_data + alu_b;
      ALU_SUB: alu_result = rs1_data - alu_b;
      ALU_AND: alu_result = rs1_data & alu_b;
      ALU_OR:  alu_result = rs1_data | alu_b;
      ALU_SLT: alu_result = ($signed(rs1_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'h0000_0000;
    endcase
  end

  assign zero = (alu_result == 32'h0000_0000);
  assign take = jump | (branch & zero);
  assign pc_d = take ? (pc_q + imm) : pc_plus4;

  data_mem #(.DEPTH(DMEM_DEPTH)) dataMem (
    .CLK   (CLK),
    .we    (mem_write & ~rst),
    .addr  (alu_result[DAW-1:0]),
    .wdata (rs2_data),
    .rdata (mem_rdata)
  );

  // Writeback source select.
  always_comb begin
    case (wb_sel)
      WB_ALU:  wb_data = alu_result;
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end
endmodule

// File: tb/tb_riscv_single_cycle_top.sv
// Directed program from the test plan followed by a random program checked against an ISA-level model.
module tb_riscv_single_cycle_top;
  localparam int IMEM = 64;
  localparam int DMEM = 16384;
  localparam int OPL  = 7'b0000011;
  localparam int OPI  = 7'b0010011;

  logic CLK = 1'b1;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rom_img [0:IMEM-1];
  logic [31:0] m_regs  [0:31];
  logic [31:0] m_mem   [0:DMEM-1];
  logic [31:0] m_pc;
  int          store_idx;

  riscv_single_cycle_top #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (.CLK(CLK), .rst(rst));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int off, input int rs1, input int rs2);
    logic [12:0] v;
    v = 13'(off);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [20:0] v;
    v = 21'(off);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  // Executes one instruction on the model state following the ISA rules directly.
  task automatic model_step();
    logic [31:0] ins, a, b, res, nxt, addr;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          rd, rs1, rs2, imm_i, imm_s, imm_b, imm_j, hi;
    logic        wr;
    ins = (int'(m_pc >> 2) < IMEM) ? rom_img[int'(m_pc >> 2)] : 32'h0000_0013;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
    a = m_regs[rs1]; b = m_regs[rs2];
    imm_i = $signed(ins) >>> 20;
    hi    = $signed(ins) >>> 25;
    imm_s = hi * 32 + int'(ins[11:7]);
    imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    nxt = m_pc + 32'd4; wr = 1'b0; res = 32'h0; store_idx = -1;
    case (op)
      7'b0000011: if (f3 == 3'b010) begin addr = a + imm_i; wr = 1'b1; res = m_mem[int'(addr[13:0])]; end
      7'b0100011: if (f3 == 3'b010) begin addr = a + imm_s; store_idx = int'(addr[13:0]); m_mem[store_idx] = b; end
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'h00) begin wr = 1'b1; res = a + b; end
        if (f3 == 3'b000 && f7 == 7'h20) begin wr = 1'b1; res = a - b; end
        if (f3 == 3'b111 && f7 == 7'h00) begin wr = 1'b1; res = a & b; end
        if (f3 == 3'b110 && f7 == 7'h00) begin wr = 1'b1; res = a | b; end
        if (f3 == 3'b010 && f7 == 7'h00) begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      end
      7'b0010011: begin
        if (f3 == 3'b000) begin wr = 1'b1; res = a + imm_i; end
        if (f3 == 3'b111) begin wr = 1'b1; res = a & 32'(imm_i); end
        if (f3 == 3'b110) begin wr = 1'b1; res = a | 32'(imm_i); end
        if (f3 == 3'b010) begin wr = 1'b1; res = ($signed(a) < imm_i) ? 32'd1 : 32'd0; end
      end
      7'b1100011: if (f3 == 3'b000 && a == b) nxt = m_pc + imm_b;
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + imm_j; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] gen_instr(input int i);
    int rd, rs1, rs2, imm, t;
    int f3s [4] = '{0, 7, 6, 2};
    rd  = int'($urandom_range(0, 31));
    rs1 = int'($urandom_range(0, 31));
    rs2 = int'($urandom_range(0, 31));
    imm = int'($urandom_range(0, 4095)) - 2048;
    t   = int'($urandom_range(0, IMEM - 2));
    case ($urandom_range(0, 11))
      0:       return enc_i(imm, rs1, 2, rd, OPL);
      1:       return enc_s(imm, rs2, rs1);
      2:       return enc_r(0, rs2, rs1, 0, rd);
      3:       return enc_r(32, rs2, rs1, 0, rd);
      4:       return enc_r(0, rs2, rs1, 7, rd);
      5:       return enc_r(0, rs2, rs1, 6, rd);
      6:       return enc_r(0, rs2, rs1, 2, rd);
      7:       return enc_i(imm, rs1, f3s[$urandom_range(0, 3)], rd, OPI);
      8:       return enc_b((t - i) * 4, rs1, ($urandom_range(0, 1) == 0) ? rs1 : rs2);
      9:       return enc_j((t - i) * 4, rd);
      10:      return enc_r(0, rs2, rs1, 4, rd);
      default: return {20'($urandom), 5'(rd), 7'b0110111};
    endcase
  endfunction

  initial begin
    logic [31:0] prog [0:23];
    logic [31:0] v;
    prog = '{enc_i(-4, 9, 2, 2, OPL), enc_i(4, 9, 2, 1, OPL), enc_i(8, 9, 2, 3, OPL),
             enc_r(32, 1, 3, 0, 3), enc_r(0, 3, 2, 2, 4), enc_b(8, 4, 0), enc_r(0, 1, 2, 0, 5),
             enc_i(7, 0, 0, 0, OPI), enc_j(8, 1), enc_i(2047, 0, 0, 5, OPI), enc_r(0, 0, 0, 0, 7),
             enc_i(4, 9, 2, 1, OPL), enc_i(6, 2, 2, 4, OPI), enc_b(8, 4, 0), enc_r(0, 1, 2, 0, 5),
             enc_i(32'h48D, 0, 0, 5, OPI), enc_r(0, 5, 5, 0, 5), enc_r(0, 5, 5, 0, 5),
             enc_s(8, 5, 9), enc_i(8, 9, 2, 6, OPL), enc_i(32'hF0, 5, 7, 8, OPI),
             enc_r(0, 2, 8, 6, 10), enc_r(0, 1, 3, 7, 11), enc_b(0, 0, 0)};
    // Preload while reset is held.
    #1;
    for (int i = 0; i < IMEM; i++) dut.instMem.rom[i] = (i < 24) ? prog[i] : 32'h0000_0013;
    for (int i = 0; i < 32; i++) dut.regFile.registers[i] = 32'h0;
    for (int i = 0; i < DMEM; i++) dut.dataMem.mem[i] = 32'h0;
    dut.regFile.registers[4] = 32'h44;
    dut.regFile.registers[5] = 32'h0BAD_F00D;
    dut.regFile.registers[7] = 32'h77;
    dut.regFile.registers[9] = 32'h2004;
    dut.dataMem.mem[32'h2000] = 32'd5;
    dut.dataMem.mem[32'h2008] = 32'hA;
    dut.dataMem.mem[32'h200C] = 32'd1;
    #49 chk("reset_pc_50ns", dut.pc_q, 32'h0);
    #20 chk("reset_pc_70ns", dut.pc_q, 32'h0);
    #5 rst = 1'b0;
    #1 chk("pc_after_release", dut.pc_q, 32'h0);

    run(3);
    chk("lw_x2", dut.regFile.registers[2], 32'd5);
    chk("lw_x1", dut.regFile.registers[1], 32'hA);
    chk("lw_x3", dut.regFile.registers[3], 32'd1);
    chk("pc_3cyc", dut.pc_q, 32'hC);
    run(1); chk("sub_x3", dut.regFile.registers[3], 32'hFFFF_FFF7);
    run(1); chk("slt_x4", dut.regFile.registers[4], 32'h0);
    run(1); chk("beq_taken_pc", dut.pc_q, 32'h1C);
    run(1); chk("x0_after_addi", dut.regFile.registers[0], 32'h0);
    chk("pc_before_jal", dut.pc_q, 32'h20);
    run(1); chk("jal_x1", dut.regFile.registers[1], 32'h24);
    chk("jal_pc", dut.pc_q, 32'h28);
    chk("x5_skipped", dut.regFile.registers[5], 32'h0BAD_F00D);
    run(1); chk("add_x7_x0", dut.regFile.registers[7], 32'h0);
    run(1); chk("reload_x1", dut.regFile.registers[1], 32'hA);
    run(1); chk("slti_x4", dut.regFile.registers[4], 32'd1);
    run(1); chk("beq_not_taken_pc", dut.pc_q, 32'h38);
    run(1); chk("add_x5", dut.regFile.registers[5], 32'hF);
    run(3); chk("build_x5", dut.regFile.registers[5], 32'h1234);
    run(1); chk("sw_mem", dut.dataMem.mem[32'h200C], 32'h1234);
    run(1); chk("lw_after_sw", dut.regFile.registers[6], 32'h1234);
    run(1); chk("andi_x8", dut.regFile.registers[8], 32'h30);
    run(1); chk("or_x10", dut.regFile.registers[10], 32'h35);
    run(1); chk("and_x11", dut.regFile.registers[11], 32'h2);
    run(3); chk("loop_pc", dut.pc_q, 32'h5C);

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1 chk("async_reset_pc", dut.pc_q, 32'h0);
    chk("reset_keeps_x6", dut.regFile.registers[6], 32'h1234);
    chk("reset_keeps_mem", dut.dataMem.mem[32'h200C], 32'h1234);
    dut.regFile.registers[2] = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    chk("no_write_in_reset", dut.regFile.registers[2], 32'hDEAD_BEEF);
    chk("pc_held_in_reset", dut.pc_q, 32'h0);
    #2 rst = 1'b0;
    run(1);
    chk("restart_lw_x2", dut.regFile.registers[2], 32'd5);
    chk("restart_pc", dut.pc_q, 32'h4);

    // Random program against the model.
    #1 rst = 1'b1;
    for (int i = 0; i < IMEM - 1; i++) rom_img[i] = gen_instr(i);
    rom_img[IMEM-1] = enc_j(-(IMEM - 1) * 4, 0);
    for (int i = 0; i < IMEM; i++) dut.instMem.rom[i] = rom_img[i];
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h0 : $urandom;
      m_regs[i] = v;
      dut.regFile.registers[i] = v;
    end
    for (int i = 0; i < DMEM; i++) begin
      v = $urandom;
      m_mem[i] = v;
      dut.dataMem.mem[i] = v;
    end
    m_pc = 32'h0;
    #2 rst = 1'b0;
    repeat (300) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk("rand_pc", dut.pc_q, m_pc);
      for (int r = 0; r < 32; r++) chk($sformatf("rand_x%0d", r), dut.regFile.registers[r], m_regs[r]);
      if (store_idx >= 0) chk($sformatf("rand_mem_%0h", store_idx), dut.dataMem.mem[store_idx], m_mem[store_idx]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_single_cycle_top.md
Name: riscv_single_cycle_top

Overview:
- Top level of a single-cycle RV32I subset processor. Every instruction is fetched, decoded, executed and retired in one CLK cycle.
- Contains the PC register, instruction ROM, register file, ALU, immediate generator, main decoder/ALU decoder and a word data memory.
- Only primary inputs are clock and reset. State is observed hierarchically through fixed instance and array names.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words in the ROM.
- DMEM_DEPTH, 16384, number of 32-bit data memory entries.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.

Behaviour:
- Hierarchy (fixed names, bench-visible):
  - instMem.rom[0:IMEM_DEPTH-1] of 32 bits, loadable by $readmemh.
  - regFile.registers[0:31] of 32 bits.
  - dataMem.mem[0:DMEM_DEPTH-1] of 32 bits.
- Reset: rst=1 forces PC=0 immediately and holds it. Register file and data memory are NOT cleared, so preloaded contents survive reset. While rst=1, no register or memory writes occur.
- Fetch: instr = rom[PC[31:2]] (word index). Out-of-range index returns 0x00000013 (nop).
- PC update at each rising CLK edge: PC <= branch/jump taken ? PC+imm : PC+4.
- Register file:
  - 2 combinational read ports; x0 always reads 0.
  - 1 write port at rising CLK edge when RegWrite=1; writes to x0 are ignored.
- Data memory: combinational read; write at rising CLK edge on sw. Entry index = ALU result[13:0] used directly, without a >>2 shift, so mem[0x2000] is address 0x2000. Only word accesses; no byte lanes.
- Supported instructions; all others execute as a nop (no writes, PC+4):
  - lw: opcode 0000011.
  - sw: opcode 0100011.
  - R-type add/sub/and/or/slt: opcode 0110011.
  - I-type addi/andi/ori/slti: opcode 0010011.
  - beq: opcode 1100011.
  - jal: opcode 1101111; rd <= PC+4.
- Immediates, all sign-extended:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- ALU: 32-bit. add/sub wrap modulo 2^32. slt is a signed compare producing 1 or 0. Zero flag = (result==0). beq is taken when the subtract result is zero.
- Writeback mux selects ALU result, memory read data, or PC+4 (jal).
- Simultaneous events: a rd that is also rs reads the old value in the same cycle; the new value is visible next cycle. A sw and a lw to the same address in consecutive cycles returns the stored data.

Test Plan:
- Preload x9=0x2004, mem[0x2000]=5, mem[0x2008]=0xA, mem[0x200C]=1. Pulse rst 45–75 ns; during rst PC=0. Then run lw x2,-4(x9); lw x1,4(x9); lw x3,8(x9) -> x2=5, x1=0xA, x3=1 after 3 cycles; PC=0xC.
- Continue with sub x3,x3,x1; slt x4,x2,x3; beq x4,x0,L1; add x5,x2,x1:
  - x3=0xFFFFFFF7.
  - x4=0 (signed 5 < -9 false).
  - Branch taken to L1, so add x5 is skipped and x5 is unchanged.
- beq not taken (x4=1 case) -> PC advances by 4, and add x5,x2,x1 writes x5=0xF.
- sw x5,8(x9) with x5=0x1234 -> mem[0x200C]=0x1234; a following lw x6,8(x9) gives x6=0x1234.
- addi x0,x0,7 then add x7,x0,x0 -> x0 reads 0 and x7=0. jal x1,+8 at PC=0x20 -> x1=0x24, PC=0x28.
- Assert rst mid-program at a time not aligned to CLK -> PC=0 immediately with no clock edge. Registers and memory keep their values, and execution restarts at instruction 0 after release.
